// File: rtl/cmp_pipe_pkg.sv
// Shared types for the pipelined comparator: op encoding, stage-1 partial compare
// bundle, and the function that folds the partials into the final result.
package cmp_pipe_pkg;

  localparam int CMP_PIPE_MAX_STAGES = 4;

  typedef enum logic [2:0] {
    CMP_NO  = 3'd0,
    CMP_EQ  = 3'd1,
    CMP_NE  = 3'd2,
    CMP_LT  = 3'd3,
    CMP_GE  = 3'd4,
    CMP_LTU = 3'd5,
    CMP_GEU = 3'd6
  } cmp_op_enum;

  typedef struct packed {
    logic hi_eq;
    logic hi_lt_s;
    logic hi_lt_u;
    logic lo_eq;
    logic lo_lt_u;
  } cmp_partial_t;

  // Only the high half carries the sign; the low half is always an unsigned compare.
  function automatic logic cmp_combine(input cmp_partial_t p, input cmp_op_enum op);
    logic eq;
    logic lt;
    logic ltu;
    logic res;
    eq  = p.hi_eq & p.lo_eq;
    ltu = p.hi_lt_u | (p.hi_eq & p.lo_lt_u);
    lt  = p.hi_lt_s | (p.hi_eq & p.lo_lt_u);
    case (op)
      CMP_EQ:  res = eq;
      CMP_NE:  res = ~eq;
      CMP_LT:  res = lt;
      CMP_GE:  res = ~lt;
      CMP_LTU: res = ltu;
      CMP_GEU: res = ~ltu;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_pipe_slice.sv
// One elastic register stage: holds a valid bit and a payload, accepts when empty or
// when the downstream stage takes its current content; flush clears the valid bit.
module cmp_pipe_slice #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 v_q;
  logic                 v_d;
  logic [PAYLOAD_W-1:0] data_q;
  logic [PAYLOAD_W-1:0] data_d;
  logic                 adv;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    adv    = !v_q || out_ready;
    v_d    = v_q;
    data_d = data_q;
    if (adv) begin
      v_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
    if (flush) begin
      v_d = 1'b0;
    end
  end

  // NOTE: payload is reset too, so the decoded result and tag read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined WIDTH-bit comparator with valid/ready handshake, tag pass-through and flush.
// Optional min/max output enabled by defining CMP_MINMAX_EN.
module cmp_pipe
  import cmp_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  cmp_op_enum       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] out_minmax
`endif
);

  localparam int HALF     = WIDTH / 2;
  localparam int OP_W     = $bits(cmp_op_enum);
  localparam int PART_W   = $bits(cmp_partial_t);
  localparam int OP_LSB   = PART_W;
  localparam int TAG_LSB  = OP_LSB + OP_W;
`ifdef CMP_MINMAX_EN
  localparam int OPND_LSB  = TAG_LSB + TAG_W;
  localparam int PAYLOAD_W = OPND_LSB + 2 * WIDTH;
`else
  localparam int PAYLOAD_W = TAG_LSB + TAG_W;
`endif

  if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("cmp_pipe: WIDTH must be even and >= 8");
  end
  if (STAGES < 1 || STAGES > CMP_PIPE_MAX_STAGES) begin : g_bad_stages
    $error("cmp_pipe: STAGES out of range");
  end

  cmp_partial_t         s1_part;
  logic [PAYLOAD_W-1:0] s1_payload;

  // The half-word compares are the only wide logic; doing them before the first
  // register keeps the output combine down to a couple of gates.
  always_comb begin
    s1_part         = '0;
    s1_part.hi_eq   = in_a[WIDTH-1:HALF] == in_b[WIDTH-1:HALF];
    s1_part.hi_lt_s = $signed(in_a[WIDTH-1:HALF]) < $signed(in_b[WIDTH-1:HALF]);
    s1_part.hi_lt_u = in_a[WIDTH-1:HALF] < in_b[WIDTH-1:HALF];
    s1_part.lo_eq   = in_a[HALF-1:0] == in_b[HALF-1:0];
    s1_part.lo_lt_u = in_a[HALF-1:0] < in_b[HALF-1:0];
`ifdef CMP_MINMAX_EN
    s1_payload = {in_a, in_b, in_tag, in_op, s1_part};
`else
    s1_payload = {in_tag, in_op, s1_part};
`endif
  end

  logic [STAGES-1:0] v_all;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 us_valid;
    logic [PAYLOAD_W-1:0] us_data;
    logic                 ds_ready;
    logic                 s_ready;
    logic                 s_valid;
    logic [PAYLOAD_W-1:0] s_data;

    if (k == 0) begin : g_first
      assign us_valid = in_valid;
      assign us_data  = s1_payload;
    end else begin : g_pass
      assign us_valid = g_stage[k-1].s_valid;
      assign us_data  = g_stage[k-1].s_data;
    end

    if (k == STAGES - 1) begin : g_last
      assign ds_ready = out_ready;
    end else begin : g_mid
      assign ds_ready = g_stage[k+1].s_ready;
    end

    cmp_pipe_slice #(
      .PAYLOAD_W(PAYLOAD_W)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (us_valid),
      .in_ready (s_ready),
      .in_data  (us_data),
      .out_valid(s_valid),
      .out_ready(ds_ready),
      .out_data (s_data)
    );

    assign v_all[k] = s_valid;
  end

  logic [PAYLOAD_W-1:0] last_data;
  cmp_partial_t         last_part;
  cmp_op_enum           last_op;

  assign last_data = g_stage[STAGES-1].s_data;
  assign last_part = cmp_partial_t'(last_data[PART_W-1:0]);
  assign last_op   = cmp_op_enum'(last_data[OP_LSB +: OP_W]);

  assign in_ready  = g_stage[0].s_ready;
  assign out_valid = v_all[STAGES-1];
  assign busy      = |v_all;
  assign out_res   = cmp_combine(last_part, last_op);
  assign out_tag   = last_data[TAG_LSB +: TAG_W];

`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] last_a;
  logic [WIDTH-1:0] last_b;

  assign last_b = last_data[OPND_LSB +: WIDTH];
  assign last_a = last_data[OPND_LSB + WIDTH +: WIDTH];

  // Less-than ops pick the min and greater-or-equal ops the max; both reduce to res ? a : b.
  always_comb begin
    out_minmax = last_a;
    if (last_op == CMP_LT || last_op == CMP_LTU || last_op == CMP_GE || last_op == CMP_GEU) begin
      out_minmax = out_res ? last_a : last_b;
    end
  end
`endif

endmodule
